// File: rtl/sensor_conditioner.sv
// Purpose: synchronize and debounce the two gate photo-sensor pins, flag a beam blocked too long.
// Latency: raw pin to clean level is DEBOUNCE_CYCLES+2 edges; fault rises STUCK_CYCLES edges after level.
// Backpressure: none; free-running sampler, all outputs come straight from flops.

// One sensor channel: 2-flop synchronizer, counter debouncer, stuck-high detector.
module sensor_conditioner_chan #(
  parameter int unsigned DEBOUNCE_CYCLES = 500000,
  parameter int unsigned STUCK_CYCLES    = 50000000
) (
  input  logic clk,
  input  logic reset,
  input  logic raw_i,
  output logic out_o,
  output logic fault_o
);

  localparam int DW = $clog2(DEBOUNCE_CYCLES) + 1;
  localparam int SW = $clog2(STUCK_CYCLES) + 1;

  localparam logic [DW-1:0] DCNT_LAST = DW'(DEBOUNCE_CYCLES - 1);
  localparam logic [DW-1:0] DCNT_ONE  = DW'(1);
  localparam logic [SW-1:0] SCNT_MAX  = SW'(STUCK_CYCLES);
  localparam logic [SW-1:0] SCNT_LAST = SW'(STUCK_CYCLES - 1);
  localparam logic [SW-1:0] SCNT_ONE  = SW'(1);

  logic          s1_q, s0_q;
  logic          out_q, out_d;
  logic          fault_q, fault_d;
  logic [DW-1:0] dcnt_q, dcnt_d;
  logic [SW-1:0] scnt_q, scnt_d;

  // Debounce: count consecutive samples that disagree with the clean level; any agreement restarts.
  always_comb begin
    dcnt_d = dcnt_q;
    out_d  = out_q;
    if (s0_q == out_q) begin
      dcnt_d = '0;
    end else if (dcnt_q == DCNT_LAST) begin
      out_d  = s0_q;
      dcnt_d = '0;
    end else begin
      dcnt_d = dcnt_q + DCNT_ONE;
    end
  end

  // Stuck detect: saturating count of cycles the clean level is high; fault sets as it reaches the limit.
  always_comb begin
    scnt_d  = scnt_q;
    fault_d = fault_q;
    if (!out_q) begin
      scnt_d  = '0;
      fault_d = 1'b0;
    end else if (scnt_q != SCNT_MAX) begin
      scnt_d = scnt_q + SCNT_ONE;
      if (scnt_q == SCNT_LAST) begin
        fault_d = 1'b1;
      end
    end
  end

  // State registers; reset clears everything including the synchronizer so no stale sample survives.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      s1_q    <= 1'b0;
      s0_q    <= 1'b0;
      dcnt_q  <= '0;
      out_q   <= 1'b0;
      scnt_q  <= '0;
      fault_q <= 1'b0;
    end else begin
      s1_q    <= raw_i;
      s0_q    <= s1_q;
      dcnt_q  <= dcnt_d;
      out_q   <= out_d;
      scnt_q  <= scnt_d;
      fault_q <= fault_d;
    end
  end

  assign out_o   = out_q;
  assign fault_o = fault_q;

endmodule

// Two identical, independent channels: a = outer beam, b = inner beam.
module sensor_conditioner #(
  parameter int unsigned DEBOUNCE_CYCLES = 500000,
  parameter int unsigned STUCK_CYCLES    = 50000000
) (
  input  logic clk,
  input  logic reset,
  input  logic a_raw,
  input  logic b_raw,
  output logic a,
  output logic b,
  output logic a_fault,
  output logic b_fault
);

  sensor_conditioner_chan #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .STUCK_CYCLES   (STUCK_CYCLES)
  ) u_chan_a (
    .clk    (clk),
    .reset  (reset),
    .raw_i  (a_raw),
    .out_o  (a),
    .fault_o(a_fault)
  );

  sensor_conditioner_chan #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .STUCK_CYCLES   (STUCK_CYCLES)
  ) u_chan_b (
    .clk    (clk),
    .reset  (reset),
    .raw_i  (b_raw),
    .out_o  (b),
    .fault_o(b_fault)
  );

endmodule

// File: tb/tb_sensor_conditioner.sv
// Directed bench for sensor_conditioner with DEBOUNCE_CYCLES=4, STUCK_CYCLES=20.
// Inputs change and outputs are sampled 1 time unit after each rising edge.
// Expected values are hand-derived edge counts from the point an input changes.
module tb_sensor_conditioner;

  logic clk;
  logic reset;
  logic a_raw, b_raw;
  logic a, b, a_fault, b_fault;

  int total;
  int bad;

  sensor_conditioner #(
    .DEBOUNCE_CYCLES(4),
    .STUCK_CYCLES   (20)
  ) dut (
    .clk    (clk),
    .reset  (reset),
    .a_raw  (a_raw),
    .b_raw  (b_raw),
    .a      (a),
    .b      (b),
    .a_fault(a_fault),
    .b_fault(b_fault)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic chkn(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic chk_out(input string tag, input logic ea, input logic eb,
                         input logic efa, input logic efb);
    chk1({tag, ".a"}, a, ea);
    chk1({tag, ".b"}, b, eb);
    chk1({tag, ".a_fault"}, a_fault, efa);
    chk1({tag, ".b_fault"}, b_fault, efb);
  endtask

  initial begin
    total = 0;
    bad   = 0;
    reset = 1'b1;
    a_raw = 1'b1;
    b_raw = 1'b1;

    // Reset held with both beams blocked: everything stays 0.
    #2 reset = 1'b0;
    #1;
    chk_out("rst_async", 1'b0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 10; i++) begin
      step();
      chk_out("rst_hold", 1'b0, 1'b0, 1'b0, 1'b0);
    end

    // Release: a and b rise exactly 6 edges later.
    reset = 1'b1;
    for (int i = 1; i <= 6; i++) begin
      step();
      chk1("rst_rel_a", a, 1'(i == 6));
      chk1("rst_rel_b", b, 1'(i == 6));
    end
    a_raw = 1'b0;
    b_raw = 1'b0;
    repeat (6) step();
    chk1("rel_fall_a", a, 1'b0);
    chk1("rel_fall_b", b, 1'b0);
    repeat (3) step();
    chk_out("idle0", 1'b0, 1'b0, 1'b0, 1'b0);

    // Glitch: 3 high cycles are rejected and the counter returns to 0.
    a_raw = 1'b1;
    repeat (3) begin
      step();
      chk1("glitch_a", a, 1'b0);
    end
    chkn("glitch_dcnt_e3", 32'(dut.u_chan_a.dcnt_q), 32'd1);
    a_raw = 1'b0;
    step();
    chk1("glitch_a_e4", a, 1'b0);
    chkn("glitch_dcnt_e4", 32'(dut.u_chan_a.dcnt_q), 32'd2);
    step();
    chk1("glitch_a_e5", a, 1'b0);
    chkn("glitch_dcnt_e5", 32'(dut.u_chan_a.dcnt_q), 32'd3);
    step();
    chk1("glitch_a_e6", a, 1'b0);
    chkn("glitch_dcnt_e6", 32'(dut.u_chan_a.dcnt_q), 32'd0);
    repeat (3) begin
      step();
      chk1("glitch_a_after", a, 1'b0);
    end

    // 4 high cycles: a pulses high on edges 6..9.
    a_raw = 1'b1;
    for (int i = 1; i <= 10; i++) begin
      step();
      if (i == 4) a_raw = 1'b0;
      chk1("pulse_a", a, 1'(i >= 6 && i <= 9));
    end
    repeat (3) step();

    // Bounce: toggle every cycle, a never moves; settle at 1 -> rises 6 edges later.
    for (int i = 0; i < 20; i++) begin
      a_raw = ~a_raw;
      step();
      chk1("bounce_a", a, 1'b0);
    end
    a_raw = 1'b1;
    for (int i = 1; i <= 6; i++) begin
      step();
      chk1("settle_a", a, 1'(i == 6));
    end
    a_raw = 1'b0;
    repeat (6) step();
    chk1("settle_fall_a", a, 1'b0);
    repeat (3) step();
    chk_out("idle1", 1'b0, 1'b0, 1'b0, 1'b0);

    // Independence: b drops after 2 cycles and never debounces; a rises at +6.
    a_raw = 1'b1;
    b_raw = 1'b1;
    for (int i = 1; i <= 6; i++) begin
      step();
      if (i == 2) b_raw = 1'b0;
      chk1("indep_a", a, 1'(i == 6));
      chk1("indep_b", b, 1'b0);
    end

    // Stuck: a_fault rises 20 edges after a, then saturates.
    for (int i = 7; i <= 25; i++) begin
      step();
      chk1("stuck_a", a, 1'b1);
      chk1("stuck_fault_lo", a_fault, 1'b0);
      chk1("stuck_b_fault", b_fault, 1'b0);
    end
    step();
    chk1("stuck_fault_rise", a_fault, 1'b1);
    chkn("stuck_scnt_20", 32'(dut.u_chan_a.scnt_q), 32'd20);
    repeat (5) step();
    chk1("stuck_fault_hold", a_fault, 1'b1);
    chkn("stuck_scnt_sat", 32'(dut.u_chan_a.scnt_q), 32'd20);

    // Release beam: a falls at +6, fault clears one edge after.
    a_raw = 1'b0;
    for (int i = 1; i <= 7; i++) begin
      step();
      chk1("unstuck_a", a, 1'(i < 6));
      chk1("unstuck_fault", a_fault, 1'(i < 7));
    end
    chkn("unstuck_scnt", 32'(dut.u_chan_a.scnt_q), 32'd0);
    repeat (2) step();

    // Reset mid-count with fault set: everything clears at once.
    a_raw = 1'b1;
    repeat (26) step();
    chk1("pre_rst_a", a, 1'b1);
    chk1("pre_rst_fault", a_fault, 1'b1);
    a_raw = 1'b0;
    repeat (4) step();
    chkn("pre_rst_dcnt", 32'(dut.u_chan_a.dcnt_q), 32'd2);
    chk1("pre_rst_a2", a, 1'b1);
    chk1("pre_rst_fault2", a_fault, 1'b1);
    #2;
    a_raw = 1'b1;
    reset = 1'b0;
    #1;
    chk_out("mid_rst", 1'b0, 1'b0, 1'b0, 1'b0);
    chkn("mid_rst_dcnt", 32'(dut.u_chan_a.dcnt_q), 32'd0);
    chkn("mid_rst_scnt", 32'(dut.u_chan_a.scnt_q), 32'd0);
    repeat (3) begin
      step();
      chk_out("mid_rst_hold", 1'b0, 1'b0, 1'b0, 1'b0);
    end
    reset = 1'b1;
    for (int i = 1; i <= 6; i++) begin
      step();
      chk1("mid_rel_a", a, 1'(i == 6));
      chk1("mid_rel_fault", a_fault, 1'b0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
